mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, byte address bits decoded for RAM; RAM holds 2^ADDR_WIDTH bytes.
REQ-002 Parameter FIFO_LOG, default 3, log2 of output-FIFO depth (depth D = 2^FIFO_LOG).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rdy  input  1  global enable; low = freeze all state except reset.
REQ-006 lw_type  input  1  1 = write byte, 0 = read byte, from the memory controller.
REQ-007 addr  input  32  byte address from the memory controller.
REQ-008 byte_out  input  8  write data from the memory controller.
REQ-009 byte_in  output  8  registered read data to the memory controller.
REQ-010 io_buffer_full  output  1  back-pressure to the memory controller.
REQ-011 tx_valid  output  1  FIFO head valid toward the serial transmitter.
REQ-012 tx_data  output  8  FIFO head byte.
REQ-013 tx_ready  input  1  transmitter accepts head when high together with tx_valid.
REQ-014 sim_end  output  1  sticky halt flag.
REQ-015 overflow  output  1  sticky FIFO-overflow error flag.

Function
REQ-016 Address decode: IO region when addr[17:16] == 2'b11; RAM otherwise, indexed by addr[ADDR_WIDTH-1:0].
REQ-017 RAM write: rdy & lw_type & RAM region -> mem[addr] <= byte_out at the edge.
REQ-018 RAM read: rdy & !lw_type & RAM region -> byte_in <= mem[addr] at the edge; read latency exactly 1 cycle.
REQ-019 Read of an address written in the same cycle returns the old byte.
REQ-020 IO write 0x30000: push byte_out into FIFO; IO write 0x30004: sim_end <= 1; other IO writes ignored.
REQ-021 IO read 0x30000 returns 8'h00; IO read 0x30004 returns {(8-FIFO_LOG-1) zeros, count}; other IO reads return 8'h00; all 1-cycle latency.
REQ-022 FIFO: circular buffer, rd/wr pointers FIFO_LOG bits wrapping modulo D, count FIFO_LOG+1 bits, range 0..D.
REQ-023 Pop: tx_valid & tx_ready -> rd pointer +1, count -1; tx_valid = (count != 0); tx_data = buf[rd pointer] combinationally.
REQ-024 Simultaneous push and pop with count in 1..D: both pointers advance, count unchanged.
REQ-025 Simultaneous push and pop with count == 0: push accepted, tx_valid stays low in that cycle (no pop), count becomes 1.
REQ-026 Push when count == D and no pop in the same cycle: byte dropped, pointers/count unchanged, overflow <= 1.
REQ-027 Push when count == D with a pop in the same cycle: accepted, no overflow.
REQ-028 io_buffer_full = (count >= D-2), combinational, giving two bytes of headroom for in-flight controller writes.
REQ-029 rdy low: no RAM write, no push, no pop, byte_in holds; tx_valid still reflects count, and a tx_ready handshake is not taken.
REQ-030 io_buffer_full does not gate this block; a write arriving while it is high is still processed per REQ-020/026.

Reset
REQ-031 rst asynchronously sets byte_in = 0, pointers = 0, count = 0, sim_end = 0, overflow = 0; consequently tx_valid = 0 and io_buffer_full = 0.
REQ-032 RAM contents are not reset; reset during an in-flight read discards it, and byte_in is 0 on the first edge after release unless a new read occurs on that edge.

Verification
REQ-033 Write 8'hA5 to 0x00010, next cycle read 0x00010 -> byte_in == 8'hA5 one cycle after the read address.
REQ-034 D=8, tx_ready=0, push 6 bytes to 0x30000 -> io_buffer_full rises after the 6th push; push 3 more -> 9th push dropped, overflow == 1, count == 8.
REQ-035 Push 8'h41, 8'h42 with tx_ready=1 -> tx_data sequence 41, 42, each valid one cycle after its push; count returns to 0.
REQ-036 Count == 3, simultaneous push and pop -> count stays 3, head advances; read 0x30004 -> byte_in == 8'h03.
REQ-037 rdy=0 during write 8'hFF to 0x00020 -> later read of 0x00020 returns prior contents; write to 0x30004 -> sim_end == 1 until rst.
REQ-038 Assert rst mid-push sequence, asynchronously between edges -> all outputs at reset values before the next edge; RAM byte written before reset is still readable.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-wide memory responder for a memory controller. Decodes
//               a RAM region (2^ADDR_WIDTH bytes, 1-cycle registered read)
//               and an IO region (addr[17:16] == 2'b11) that holds:
//                 0x30000 W : push byte into output FIFO toward transmitter
//                 0x30000 R : returns 8'h00
//                 0x30004 W : set sticky sim_end
//                 0x30004 R : returns current FIFO occupancy
//               The output FIFO (depth 2^FIFO_LOG) drains over a
//               valid/ready handshake.
// Ports       : clk, rst (async, active-high), rdy (global enable)
//               lw_type/addr/byte_out   - request from memory controller
//               byte_in                 - registered read data
//               io_buffer_full          - back-pressure (count >= D-2)
//               tx_valid/tx_data/tx_ready - FIFO head toward transmitter
//               sim_end, overflow       - sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_LOG   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        lw_type,
    input  logic [31:0] addr,
    input  logic [7:0]  byte_out,
    output logic [7:0]  byte_in,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        sim_end,
    output logic        overflow
);

    localparam int               c_mem_bytes = 1 << ADDR_WIDTH;
    localparam int               c_depth_int = 1 << FIFO_LOG;
    localparam logic [FIFO_LOG:0] c_depth    = (FIFO_LOG+1)'(c_depth_int);
    // Two slots of headroom for controller writes already in flight.
    localparam logic [FIFO_LOG:0] c_full_thr = (FIFO_LOG+1)'(c_depth_int - 2);

    logic [7:0]          r_mem [c_mem_bytes];
    logic [7:0]          r_buf [c_depth_int];
    logic [FIFO_LOG-1:0] r_wr_ptr;
    logic [FIFO_LOG-1:0] r_rd_ptr;
    logic [FIFO_LOG:0]   r_count;

    logic w_is_io;
    logic w_io_data;
    logic w_io_ctrl;
    logic w_ram_wr;
    logic w_rd_en;
    logic w_push;
    logic w_pop;
    logic w_push_ok;
    logic w_push_drop;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic [7:0] w_rd_data;
    logic w_unused_addr;

    // Upper address bits are outside both decoded regions.
    assign w_unused_addr = ^addr[31:18];

    assign w_is_io   = (addr[17:16] == 2'b11);
    assign w_io_data = w_is_io && (addr[15:0] == 16'h0000);
    assign w_io_ctrl = w_is_io && (addr[15:0] == 16'h0004);
    assign w_ram_idx = addr[ADDR_WIDTH-1:0];

    assign w_ram_wr  = rdy && lw_type && !w_is_io;
    assign w_rd_en   = rdy && !lw_type;

    assign tx_valid       = (r_count != '0);
    assign tx_data        = r_buf[r_rd_ptr];
    assign io_buffer_full = (r_count >= c_full_thr);

    // tx_valid is low when empty, so a push into an empty FIFO never pops
    // in the same cycle; a pop while full frees the slot for the push.
    assign w_pop       = rdy && tx_valid && tx_ready;
    assign w_push      = rdy && lw_type && w_io_data;
    assign w_push_ok   = w_push && ((r_count != c_depth) || w_pop);
    assign w_push_drop = w_push && (r_count == c_depth) && !w_pop;

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_io) begin
            w_rd_data = r_mem[w_ram_idx];
        end else if (w_io_ctrl) begin
            w_rd_data = 8'(r_count);
        end
    end

    // Storage arrays carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_ram_idx] <= byte_out;
        end
        if (w_push_ok) begin
            r_buf[r_wr_ptr] <= byte_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_in  <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            sim_end  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (w_rd_en) begin
                byte_in <= w_rd_data;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_drop) begin
                overflow <= 1'b1;
            end
            if (rdy && lw_type && w_io_ctrl) begin
                sim_end <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder with a reference model
//               (RAM map, FIFO queue, sticky flags) and scoreboard queues for
//               read data and transmitted bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        lw_type;
    logic [31:0] addr;
    logic [7:0]  byte_out;
    logic [7:0]  byte_in;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        sim_end;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [7:0] mem_m [int unsigned];
    logic [7:0] fifo_m [$];
    logic [7:0] rd_q [$];
    logic       ovf_m = 1'b0;
    logic       end_m = 1'b0;

    mem_responder #(.ADDR_WIDTH(17), .FIFO_LOG(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .lw_type(lw_type), .addr(addr),
        .byte_out(byte_out), .byte_in(byte_in), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .sim_end(sim_end), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic lw, input logic [31:0] a,
                         input logic [7:0] d, input logic txr);
        rdy = r; lw_type = lw; addr = a; byte_out = d; tx_ready = txr;
    endtask

    // One clock: status checks before the edge, model update, edge, read check.
    task automatic step();
        logic       pop;
        logic       is_io;
        logic [7:0] exp_rd;
        #1;
        n_cmp++;
        if (tx_valid !== (fifo_m.size() != 0)) begin
            n_bad++;
            $display("FAIL tx_valid: got %b want %b", tx_valid, fifo_m.size() != 0);
        end
        n_cmp++;
        if (io_buffer_full !== (fifo_m.size() >= 6)) begin
            n_bad++;
            $display("FAIL io_buffer_full: got %b want %b (count %0d)",
                     io_buffer_full, fifo_m.size() >= 6, fifo_m.size());
        end
        n_cmp++;
        if (overflow !== ovf_m || sim_end !== end_m) begin
            n_bad++;
            $display("FAIL flags: got ovf=%b end=%b want ovf=%b end=%b",
                     overflow, sim_end, ovf_m, end_m);
        end
        is_io = (addr[17:16] == 2'b11);
        pop = rdy && tx_ready && (fifo_m.size() != 0);
        if (pop) begin
            n_cmp++;
            if (tx_data !== fifo_m[0]) begin
                n_bad++;
                $display("FAIL tx_data: got %h want %h", tx_data, fifo_m[0]);
            end
        end
        if (rdy && !lw_type) begin
            if (!is_io) exp_rd = mem_m[addr[16:0]];
            else if (addr[15:0] == 16'h0004) exp_rd = 8'(fifo_m.size());
            else exp_rd = 8'h00;
            rd_q.push_back(exp_rd);
        end
        if (rdy && lw_type) begin
            if (!is_io) mem_m[addr[16:0]] = byte_out;
            else if (addr[15:0] == 16'h0004) end_m = 1'b1;
            else if (addr[15:0] == 16'h0000) begin
                if (fifo_m.size() == 8 && !pop) ovf_m = 1'b1;
                else fifo_m.push_back(byte_out);
            end
        end
        if (pop) void'(fifo_m.pop_front());
        @(posedge clk);
        #1;
        if (rd_q.size() != 0) begin
            exp_rd = rd_q.pop_front();
            n_cmp++;
            if (byte_in !== exp_rd) begin
                n_bad++;
                $display("FAIL byte_in: got %h want %h", byte_in, exp_rd);
            end
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        rd_q.delete();
        ovf_m = 1'b0;
        end_m = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (byte_in !== 8'h00 || tx_valid !== 1'b0 || io_buffer_full !== 1'b0 ||
            sim_end !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got byte_in=%h txv=%b full=%b end=%b ovf=%b want all 0",
                     name, byte_in, tx_valid, io_buffer_full, sim_end, overflow);
        end
    endtask

    task automatic idle(input logic txr);
        drive(1'b1, 1'b0, 32'h0001_0000 | 32'h0000_0100, 8'h00, txr);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        rst = 1'b1;
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // seed the idle-read location so background reads are well defined
        drive(1'b1, 1'b1, 32'h0001_0100, 8'h3C, 1'b0);
        step();
    endtask

    task automatic test_ram_rw();
        drive(1'b1, 1'b1, 32'h0000_0010, 8'hA5, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h0000_1000 + i, 8'($urandom_range(0, 255)), 1'b0);
            step();
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 1'b0, 32'h0000_1000 + i, 8'h00, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 32'h0001_FFFF, 8'h5E, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0003_0008, 8'h00, 1'b0); step();
    endtask

    task automatic drain();
        int budget = 40;
        while (fifo_m.size() != 0 && budget > 0) begin
            idle(1'b1);
            step();
            budget--;
        end
        n_cmp++;
        if (fifo_m.size() != 0 || tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain: got txv=%b model_count=%0d want 0", tx_valid, fifo_m.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'h10 + 8'(i), 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0); step();
        n_cmp++;
        if (byte_in !== 8'h08 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_count: got cnt=%h ovf=%b want 08 1", byte_in, overflow);
        end
        // full FIFO, push with simultaneous pop: accepted
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h77, 1'b1); step();
        drain();
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h41, 1'b1); step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h42, 1'b1); step();
        idle(1'b1); step();
        idle(1'b1); step();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b1); step();
    endtask

    task automatic test_simul_push_pop();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'hC0 + 8'(i), 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 32'h0003_0000, 8'hC3, 1'b1); step();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0); step();
        n_cmp++;
        if (byte_in !== 8'h03 || tx_data !== 8'hC1) begin
            n_bad++;
            $display("FAIL simul_push_pop: got cnt=%h head=%h want 03 c1", byte_in, tx_data);
        end
        drain();
        // empty FIFO, push with tx_ready high: no pop that cycle
        drive(1'b1, 1'b1, 32'h0003_0000, 8'hE1, 1'b1); step();
        idle(1'b1); step();
    endtask

    task automatic test_rdy_low();
        drive(1'b1, 1'b1, 32'h0000_0020, 8'h5A, 1'b0); step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h99, 1'b0); step();
        drive(1'b0, 1'b1, 32'h0000_0020, 8'hFF, 1'b1); step();
        drive(1'b0, 1'b1, 32'h0003_0000, 8'hFF, 1'b1); step();
        drive(1'b0, 1'b0, 32'h0000_0010, 8'h00, 1'b1); step();
        n_cmp++;
        if (byte_in !== 8'h3C) begin
            n_bad++;
            $display("FAIL rdy_low_hold: got %h want 3c", byte_in);
        end
        drive(1'b1, 1'b0, 32'h0000_0020, 8'h00, 1'b0); step();
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h01, 1'b0); step();
        idle(1'b0); step();
        idle(1'b0); step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h0000_0040, 8'h77, 1'b0); step();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'h50 + 8'(i), 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h60, 1'b0);
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h61, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h62, 1'b0); step();
        // in-flight read, then reset between edges
        drive(1'b1, 1'b0, 32'h0000_0040, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0050, 8'h11, 1'b0);
        @(posedge clk);
        #1;
        check_reset_outputs("reset_release");
        drive(1'b1, 1'b0, 32'h0000_0040, 8'h00, 1'b0); step();
        mem_m[17'h50] = 8'h11;
        drive(1'b1, 1'b0, 32'h0000_0050, 8'h00, 1'b0); step();
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        test_reset();
        test_ram_rw();
        test_overflow();
        test_stream();
        test_simul_push_pop();
        test_rdy_low();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
